fifo_rd_stage: RTL and testbench
================================

FIFO_RD_STAGE -- requirements
Module: fifo_rd_stage

Interface
REQ-001 Parameter BITS, default 16, data word width; matches the upstream fifo_flops BITS.
REQ-002 Parameter TAG_W, default 4, sequence-tag width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (rst=0 sampled at posedge resets the block).
REQ-005 fifo_dout  in  BITS  head word of upstream FIFO, first-word-fall-through (valid whenever fifo_pndng=1).
REQ-006 fifo_pndng  in  1  upstream FIFO non-empty.
REQ-007 fifo_pop  out  1  pop strobe to upstream FIFO; head word consumed at the same posedge.
REQ-008 out_data  out  BITS  delivered word.
REQ-009 out_tag  out  TAG_W  sequence tag of out_data.
REQ-010 out_valid  out  1  out_data/out_tag valid.
REQ-011 out_ready  in  1  downstream accepts; transfer when out_valid&&out_ready at posedge.
REQ-012 flush  in  1  level; discard buffered and pending FIFO words.
REQ-013 word_cnt  out  16  count of completed output transfers.
REQ-014 busy  out  1  block or upstream FIFO holds data.

Function
REQ-015 Two-entry skid buffer, registered storage; state machine S_EMPTY (0 entries), S_ONE (1), S_TWO (2), S_FLUSH.
REQ-016 Normal states, flush=0: fifo_pop = fifo_pndng && state!=S_TWO; no combinational path from out_ready to fifo_pop.
REQ-017 fifo_pop is never 1 while fifo_pndng=0, in any state.
REQ-018 Popped word and current tag are written into the buffer at the popping posedge; first-in, first-out order preserved.
REQ-019 out_valid = (state is S_ONE or S_TWO) && flush=0; out_data/out_tag show the oldest entry, registered.
REQ-020 Latency: word popped at edge N is presented with out_valid=1 after edge N when buffer was empty.
REQ-021 Occupancy next = current + pop - transfer; pop and transfer in the same cycle in S_ONE stay in S_ONE, giving one word per cycle throughput.
REQ-022 S_TWO with out_ready=0 holds both entries unchanged; no pop.
REQ-023 Tag counter resets to 0, increments mod 2^TAG_W per word popped in normal states; wraps 2^TAG_W-1 -> 0.
REQ-024 word_cnt increments on each transfer, saturates at 16'hFFFF.
REQ-025 flush=1 at a posedge in any normal state: buffer cleared, next state S_FLUSH; a transfer is impossible in that cycle (out_valid=0).
REQ-026 While flush=1 in a normal state, or in S_FLUSH: fifo_pop = fifo_pndng, popped words discarded, tag and word_cnt not incremented.
REQ-027 S_FLUSH exits to S_EMPTY when flush=0 and fifo_pndng=0; otherwise stays.
REQ-028 busy = (state!=S_EMPTY) || fifo_pndng.

Reset
REQ-029 rst=0: state S_EMPTY, buffer cleared, out_valid=0, out_data=0, out_tag=0, tag counter=0, word_cnt=0, fifo_pop=0 regardless of fifo_pndng.
REQ-030 Reset mid-operation discards buffered words; upstream FIFO contents are untouched by this block.

Verification
REQ-031 rst=0 for 5 cycles, fifo_pndng=1 -> fifo_pop=0, out_valid=0, word_cnt=0, out_tag=0 throughout.
REQ-032 FIFO preloaded 0..15, out_ready=1 -> out_data 0..15 on consecutive cycles, tags 0..15, word_cnt=16, busy=0 at end.
REQ-033 FIFO holds 0..7, out_ready=0 -> exactly 2 pops, state S_TWO, out_data=0 held; release out_ready -> 0..7 delivered once each, in order.
REQ-034 out_ready toggling every cycle, 16 words -> no loss or duplication; fifo_pop never 1 with fifo_pndng=0.
REQ-035 Two words buffered, 5 in FIFO, flush=1 for one cycle -> 5 discard pops, out_valid=0, word_cnt unchanged, return S_EMPTY; next word carries tag continuing from pre-flush value.
REQ-036 20 words streamed -> tags 0..15 then 0..3.

Source files
------------

// File: rtl/fifo_rd_stage.sv
// Read-side stage for a first-word-fall-through FIFO: a two-entry registered skid
// buffer that tags each word with a rolling sequence number and supports flushing.
module fifo_rd_stage #(
    parameter int BITS  = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BITS-1:0]  fifo_dout,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    output logic [BITS-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [15:0]      word_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [BITS-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic             pop_c, xfer_c, valid_c, discard_c;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        discard_c  = (state_q == S_FLUSH) || flush;
        valid_c    = ((state_q == S_ONE) || (state_q == S_TWO)) && !flush;
        xfer_c     = valid_c && out_ready;
        // Pop depends only on state and pndng so out_ready never reaches fifo_pop.
        if (!rst)
            pop_c = 1'b0;
        else if (discard_c)
            pop_c = fifo_pndng;
        else
            pop_c = fifo_pndng && (state_q != S_TWO);

        state_d    = state_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        tag0_d     = tag0_q;
        tag1_d     = tag1_q;
        tag_cnt_d  = tag_cnt_q;
        word_cnt_d = xfer_c ? sat_inc16(word_cnt_q) : word_cnt_q;

        if (discard_c) begin
            buf0_d  = '0;
            buf1_d  = '0;
            tag0_d  = '0;
            tag1_d  = '0;
            state_d = (state_q == S_FLUSH && !flush && !fifo_pndng) ? S_EMPTY : S_FLUSH;
        end else begin
            if (pop_c)
                tag_cnt_d = tag_cnt_q + 1'b1;
            case (state_q)
                S_EMPTY: begin
                    if (pop_c) begin
                        buf0_d  = fifo_dout;
                        tag0_d  = tag_cnt_q;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    case ({pop_c, xfer_c})
                        2'b11: begin
                            buf0_d = fifo_dout;
                            tag0_d = tag_cnt_q;
                        end
                        2'b10: begin
                            buf1_d  = fifo_dout;
                            tag1_d  = tag_cnt_q;
                            state_d = S_TWO;
                        end
                        2'b01: begin
                            buf0_d  = '0;
                            tag0_d  = '0;
                            state_d = S_EMPTY;
                        end
                        default: state_d = S_ONE;
                    endcase
                end
                S_TWO: begin
                    if (xfer_c) begin
                        buf0_d  = buf1_q;
                        tag0_d  = tag1_q;
                        buf1_d  = '0;
                        tag1_d  = '0;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            buf0_q     <= '0;
            buf1_q     <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            tag_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag1_d;
            tag_cnt_q  <= tag_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign fifo_pop  = pop_c;
    assign out_valid = valid_c;
    assign out_data  = buf0_q;
    assign out_tag   = tag0_q;
    assign word_cnt  = word_cnt_q;
    assign busy      = (state_q != S_EMPTY) || fifo_pndng;

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Bench for fifo_rd_stage: models the upstream FIFO and the expected in-order word
// stream (with tags) as queues, and checks every cycle against them.
module tb_fifo_rd_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fifo_dout = '0;
    logic        fifo_pndng = 1'b0;
    logic        fifo_pop;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] word_cnt;
    logic        busy;

    fifo_rd_stage #(.BITS(16), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_pndng(fifo_pndng),
        .fifo_pop  (fifo_pop),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .word_cnt  (word_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  t;
    } ent_t;

    typedef struct {
        int n_words;
        int ready_mode;   // 0 always, 1 alternate, 2 random
        int base;
        int max_cyc;
        bit consec;
        int exp_wc;
        bit exp_busy;
        int exp_last_tag;
    } vec_t;

    logic [15:0] fifo_q[$];
    ent_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          model_tag, model_wc;
    bit          flushing;
    int          cyc = 0;
    int          pop_cnt, disc_cnt, xfer_cnt, first_x, last_x;
    logic [3:0]  last_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        fifo_pndng = (fifo_q.size() > 0);
        fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
    endtask

    task automatic step();
        logic        pop_s, pndng_s, valid_s, ready_s, flush_s, rst_s;
        logic [15:0] data_s;
        logic [3:0]  tag_s;
        logic        exp_pop, exp_valid;
        @(negedge clk);
        pop_s = fifo_pop;  pndng_s = fifo_pndng; valid_s = out_valid;
        ready_s = out_ready; flush_s = flush; rst_s = rst;
        data_s = out_data; tag_s = out_tag;
        if (rst_s) begin
            exp_pop   = pndng_s && (flush_s || flushing || exp_q.size() < 2);
            exp_valid = !flush_s && !flushing && (exp_q.size() > 0);
            chk("fifo_pop", {31'b0, pop_s}, {31'b0, exp_pop});
            chk("out_valid", {31'b0, valid_s}, {31'b0, exp_valid});
            if (valid_s && exp_q.size() > 0) begin
                chk("out_data", {16'b0, data_s}, {16'b0, exp_q[0].d});
                chk("out_tag", {28'b0, tag_s}, {28'b0, exp_q[0].t});
            end
            if (valid_s && ready_s && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                last_tag = tag_s;
                xfer_cnt++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                if (model_wc < 65535) model_wc++;
            end
            if (pop_s && pndng_s && fifo_q.size() > 0) begin
                pop_cnt++;
                if (flush_s || flushing) begin
                    disc_cnt++;
                end else begin
                    exp_q.push_back('{d: fifo_q[0], t: 4'(model_tag)});
                    model_tag = (model_tag + 1) % 16;
                end
            end
            if (flush_s) begin
                exp_q.delete();
                flushing = 1'b1;
            end else if (!pndng_s) begin
                flushing = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        fifo_q.delete();
        fifo_q.push_back(16'hA5A5);
        drive_fifo();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("rst_pop", {31'b0, fifo_pop}, 32'd0);
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_wc", {16'b0, word_cnt}, 32'd0);
            chk("rst_tag", {28'b0, out_tag}, 32'd0);
            chk("rst_data", {16'b0, out_data}, 32'd0);
        end
        fifo_q.delete();
        drive_fifo();
        rst = 1'b1;
        exp_q.delete();
        model_tag = 0; model_wc = 0; flushing = 1'b0;
        pop_cnt = 0; disc_cnt = 0; xfer_cnt = 0; first_x = -1; last_x = -1;
    endtask

    task automatic drain(input int mode, input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int n = 0; n < max_cyc; n++) begin
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc % 2 == 0);
            else                out_ready = 1'($urandom_range(0, 1));
            step();
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !flushing) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        bit   to;
        vecs[0] = '{16, 0, 0,   24,  1'b1, 16, 1'b0, 15};
        vecs[1] = '{16, 1, 100, 60,  1'b0, 16, 1'b0, 15};
        vecs[2] = '{20, 0, 200, 30,  1'b1, 20, 1'b0, 3};
        vecs[3] = '{12, 2, 300, 200, 1'b0, 12, 1'b0, 11};

        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n_words; i++) fifo_q.push_back(16'(vecs[v].base + i));
            drive_fifo();
            drain(vecs[v].ready_mode, vecs[v].max_cyc, to);
            chk($sformatf("v%0d_timeout", v), {31'b0, to}, 32'd0);
            chk($sformatf("v%0d_wc", v), {16'b0, word_cnt}, vecs[v].exp_wc);
            chk($sformatf("v%0d_busy", v), {31'b0, busy}, {31'b0, vecs[v].exp_busy});
            chk($sformatf("v%0d_xfers", v), xfer_cnt, vecs[v].n_words);
            chk($sformatf("v%0d_last_tag", v), {28'b0, last_tag}, vecs[v].exp_last_tag);
            if (vecs[v].consec)
                chk($sformatf("v%0d_consecutive", v), last_x - first_x + 1, vecs[v].n_words);
        end

        // Backpressure: only two words may leave the FIFO while the sink stalls.
        do_reset();
        for (int i = 0; i < 8; i++) fifo_q.push_back(16'(i));
        drive_fifo();
        out_ready = 1'b0;
        repeat (6) step();
        chk("bp_pops", pop_cnt, 2);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_data", {16'b0, out_data}, 32'd0);
        chk("bp_fifo_left", fifo_q.size(), 6);
        drain(0, 20, to);
        chk("bp_timeout", {31'b0, to}, 32'd0);
        chk("bp_xfers", xfer_cnt, 8);
        chk("bp_wc", {16'b0, word_cnt}, 32'd8);

        // Flush with two words buffered and five pending upstream.
        do_reset();
        fifo_q.push_back(16'h0010);
        fifo_q.push_back(16'h0011);
        drive_fifo();
        out_ready = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 5; i++) fifo_q.push_back(16'(16'h0020 + i));
        drive_fifo();
        pop_cnt = 0; disc_cnt = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain(0, 12, to);
        chk("fl_timeout", {31'b0, to}, 32'd0);
        chk("fl_disc", disc_cnt, 5);
        chk("fl_pops", pop_cnt, 5);
        chk("fl_wc", {16'b0, word_cnt}, 32'd0);
        chk("fl_busy", {31'b0, busy}, 32'd0);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        fifo_q.push_back(16'h0030);
        drive_fifo();
        xfer_cnt = 0;
        drain(0, 10, to);
        chk("fl_post_timeout", {31'b0, to}, 32'd0);
        chk("fl_post_xfers", xfer_cnt, 1);
        chk("fl_tag_continue", {28'b0, last_tag}, 32'd2);

        // Random traffic with occasional flush pulses.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) fifo_q.push_back(16'($urandom));
            drive_fifo();
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0;
        drain(0, 100, to);
        chk("rnd_timeout", {31'b0, to}, 32'd0);
        chk("rnd_wc", {16'b0, word_cnt}, model_wc);
        chk("rnd_busy", {31'b0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
